// File: rtl/pwm_generate.sv
// pwm_generate -- breathing-LED PWM generator.
//
// A prescaler divides clk into fine steps, a step counter forms the PWM
// period, and a period counter paces duty updates. The duty level ramps
// 0 -> LEVELS -> 0 in a triangle, one step per update interval, holding
// each endpoint for exactly one interval.
//
// Ports:
//   clk     in   system clock, all logic on the rising edge
//   rst_n   in   synchronous reset, ACTIVE HIGH (legacy name kept)
//   pwm_sig out  registered PWM output to the LED
//
// Timing with defaults: step 5 clk, PWM period 50 clk, duty update every
// 100 clk, full breath 2000 clk.
module pwm_generate #(
  parameter int CLK_MHZ = 5,
  parameter int US_UNIT = 1,
  parameter int MS_UNIT = 1,
  parameter int S_UNIT  = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic pwm_sig
);

  localparam int STEP_CLKS = CLK_MHZ * US_UNIT;
  localparam int LEVELS    = 10 * MS_UNIT;

  // Widths cover each counter's terminal count; a floor of 1 bit keeps
  // degenerate (terminal == 0) counters legal.
  localparam int CW = (STEP_CLKS > 1) ? $clog2(STEP_CLKS) : 1;
  localparam int SW = (LEVELS > 1)    ? $clog2(LEVELS)    : 1;
  localparam int PW = (S_UNIT > 1)    ? $clog2(S_UNIT)    : 1;
  localparam int DW = $clog2(LEVELS + 1);

  logic [CW-1:0] clk_cnt;
  logic [SW-1:0] step_cnt;
  logic [PW-1:0] per_cnt;
  logic [DW-1:0] duty;
  logic          dir;

  logic step_tick, period_tick, upd_tick;

  // Each tick chains off the lower counter's terminal count on the same
  // edge, so simultaneous wraps stay aligned.
  assign step_tick   = (clk_cnt == CW'(STEP_CLKS - 1));
  assign period_tick = step_tick & (step_cnt == SW'(LEVELS - 1));
  assign upd_tick    = period_tick & (per_cnt == PW'(S_UNIT - 1));

  always_ff @(posedge clk) begin
    if (rst_n) begin
      clk_cnt  <= '0;
      step_cnt <= '0;
      per_cnt  <= '0;
      duty     <= '0;
      dir      <= 1'b0;
      pwm_sig  <= 1'b0;
    end else begin
      clk_cnt <= step_tick ? '0 : clk_cnt + CW'(1);

      if (step_tick)
        step_cnt <= (step_cnt == SW'(LEVELS - 1)) ? '0 : step_cnt + SW'(1);

      if (period_tick)
        per_cnt <= (per_cnt == PW'(S_UNIT - 1)) ? '0 : per_cnt + PW'(1);

      // Triangle ramp: turning around at an endpoint also takes a step,
      // so each endpoint is held for exactly one update interval.
      if (upd_tick) begin
        if (!dir) begin
          if (duty == DW'(LEVELS)) begin
            dir  <= 1'b1;
            duty <= duty - DW'(1);
          end else begin
            duty <= duty + DW'(1);
          end
        end else begin
          if (duty == '0) begin
            dir  <= 1'b0;
            duty <= duty + DW'(1);
          end else begin
            duty <= duty - DW'(1);
          end
        end
      end

      // Uses pre-edge counter/duty values: one clock of latency.
      pwm_sig <= (DW'(step_cnt) < duty);
    end
  end

endmodule

// File: tb/tb_pwm_generate.sv
// Scoreboard bench for pwm_generate at default parameters.
// The stimulus process pushes the expected pwm_sig for every clock edge;
// the monitor pops and compares on the following falling edge.
//
// Hand-derived expectation, n = edges since the first edge with rst_n=0:
//   duty seen by edge n  = tri(n/100), tri(k) = k%20 <= 10 ? k%20 : 20-k%20
//   step seen by edge n  = (n/5) % 10
//   pwm_sig after edge n = step < duty
// e.g. n=0..99 -> 0; n=100..104 -> 1; n=105..149 -> 0; n=1000..1099 -> 1;
// n=1100..1144 -> 1, 1145..1149 -> 0; n=2000..2099 -> 0; n=2100..2104 -> 1.
module tb_pwm_generate;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic pwm_sig;

  typedef struct {
    int   phase;  // 0 reset, 1 first run, 2 mid-run reset, 3 second run
    int   n;
    logic exp;
  } exp_t;

  exp_t q[$];
  int   compared = 0;
  int   mismatched = 0;

  pwm_generate #(.CLK_MHZ(5), .US_UNIT(1), .MS_UNIT(1), .S_UNIT(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pwm_sig (pwm_sig)
  );

  always #5 clk = ~clk;

  function automatic logic exp_pwm(input int n);
    int k, d;
    k = (n / 100) % 20;
    d = (k <= 10) ? k : 20 - k;
    return ((n / 5) % 10) < d;
  endfunction

  // One clock edge with rst_n = r; record what pwm_sig must read after it.
  task automatic tick(input logic r, input int phase, input int n,
                      input logic e);
    exp_t x;
    rst_n = r;
    @(posedge clk);
    x.phase = phase;
    x.n     = n;
    x.exp   = e;
    q.push_back(x);
    #1;
  endtask

  // Monitor: pwm_sig is sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      compared++;
      if (pwm_sig !== x.exp) begin
        mismatched++;
        $display("FAIL pwm phase=%0d n=%0d got=%b exp=%b",
                 x.phase, x.n, pwm_sig, x.exp);
      end
    end
  end

  initial begin
    int guard;

    // Reset held 11 clocks: output low throughout.
    for (int i = 0; i < 11; i++) tick(1'b1, 0, i, 1'b0);

    // Duty 0, duty 1, ramp up to the peak and the first step down,
    // then interrupted at n=1234.
    for (int n = 0; n < 1234; n++) tick(1'b0, 1, n, exp_pwm(n));

    // Mid-ramp reset for 3 clocks: output drops on the first edge.
    for (int i = 0; i < 3; i++) tick(1'b1, 2, i, 1'b0);

    // Restart must replay from duty 0, through a full breath (back to
    // duty 0 at 2000..2099) and into the next ramp at 2100.
    for (int n = 0; n < 2200; n++) tick(1'b0, 3, n, exp_pwm(n));

    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      mismatched++;
      $display("FAIL drain left=%0d required=0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
